// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory-access and writeback pipeline stage. It drives a single-request
// data-memory bus (request held until a one-cycle ack), extracts and extends
// load data, and registers the writeback bundle for the register file.
//
// Optional build macro: MEMWB_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses go straight to the error state
//               without issuing a bus request.
//   undefined : low address bits are ignored for alignment purposes.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   mem_size, mem_se, mem_rw      access size, sign-extend, store(1)/load(0)
//   mem_enable, load_instr        access request, load writeback select
//   rf_enable                     instruction writes the register file
//   MEM_ALU, MEM_PA               address / ALU result, store data
//   MEM_rd, MEM_PC8, MEM_R31      destination, link address, link flag
//   dm_req, dm_we, dm_addr,
//   dm_be, dm_wdata               data-memory request side
//   dm_rdata, dm_ack              data-memory response side
//   stall                         upstream hold
//   WB_data, WB_rd, WB_rf_enable  registered writeback bundle
//   bus_err                       sticky timeout / alignment error
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_size,
    input  logic        mem_se,
    input  logic        mem_rw,
    input  logic        mem_enable,
    input  logic        load_instr,
    input  logic        rf_enable,
    input  logic [31:0] MEM_ALU,
    input  logic [31:0] MEM_PA,
    input  logic [4:0]  MEM_rd,
    input  logic [8:0]  MEM_PC8,
    input  logic        MEM_R31,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic [31:0] WB_data,
    output logic [4:0]  WB_rd,
    output logic        WB_rf_enable,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT8 = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE, ST_ERR} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [31:0] r_rdata;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic        r_wb_rf;
    logic        r_bus_err;

    logic        w_stall, w_commit, w_set_err, w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load, w_wb_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

`ifdef MEMWB_MISALIGN_TRAP_EN
    always_comb begin
        case (mem_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = MEM_ALU[0];
            default: w_misalign = |MEM_ALU[1:0];
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Lane enables and lane-replicated store data.
    always_comb begin
        case (mem_size)
            2'b00: begin
                w_be    = 4'b0001 << MEM_ALU[1:0];
                w_wdata = {4{MEM_PA[7:0]}};
            end
            2'b01: begin
                w_be    = MEM_ALU[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{MEM_PA[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = MEM_PA;
            end
        endcase
    end

    // Move the addressed lane of the captured read data down to bit 0.
    always_comb begin
        case (MEM_ALU[1:0])
            2'b00:   w_byte = r_rdata[7:0];
            2'b01:   w_byte = r_rdata[15:8];
            2'b10:   w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = MEM_ALU[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (mem_size)
            2'b00:   w_load = {{24{mem_se & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{mem_se & w_half[15]}}, w_half};
            default: w_load = r_rdata;
        endcase
    end

    // Stores never take read data, even if load_instr is set.
    assign w_wb_data = MEM_R31              ? {23'b0, MEM_PC8} :
                       (load_instr & ~mem_rw) ? w_load :
                                                MEM_ALU;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_commit     = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_enable) begin
                    w_stall = 1'b1;
                    if (w_misalign) begin
                        w_state_next = ST_ERR;
                        w_set_err    = 1'b1;
                    end else begin
                        w_state_next = ST_REQ;
                        w_cnt_next   = 8'd0;
                    end
                end else begin
                    w_commit = 1'b1;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (dm_ack) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                    if (r_cnt + 8'd1 == TIMEOUT8) begin
                        w_state_next = ST_ERR;
                        w_set_err    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_rdata   <= 32'd0;
            r_wb_data <= 32'd0;
            r_wb_rd   <= 5'd0;
            r_wb_rf   <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_REQ && dm_ack) begin
                r_rdata <= dm_rdata;
            end
            // Bubbles and error cycles register a disabled write.
            r_wb_rf <= w_commit & rf_enable;
            if (w_commit) begin
                r_wb_data <= w_wb_data;
                r_wb_rd   <= MEM_R31 ? 5'd31 : MEM_rd;
            end
            if (w_set_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign dm_req       = (r_state == ST_REQ);
    assign dm_we        = dm_req & mem_rw;
    assign dm_be        = dm_req ? w_be : 4'b0000;
    assign dm_addr      = {MEM_ALU[31:2], 2'b00};
    assign dm_wdata     = w_wdata;
    // Gated by reset so a held mem_enable cannot show stall during reset.
    assign stall        = reset & w_stall;
    assign WB_data      = r_wb_data;
    assign WB_rd        = r_wb_rd;
    assign WB_rf_enable = r_wb_rf;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int T = 15;
`ifdef MEMWB_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, reset;
    logic [1:0]  mem_size;
    logic        mem_se, mem_rw, mem_enable, load_instr, rf_enable;
    logic [31:0] MEM_ALU, MEM_PA;
    logic [4:0]  MEM_rd;
    logic [8:0]  MEM_PC8;
    logic        MEM_R31;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ack, stall;
    logic [31:0] WB_data;
    logic [4:0]  WB_rd;
    logic        WB_rf_enable, bus_err;

    int n_checks = 0;
    int n_errors = 0;
    int txn_no   = 0;

    mem_wb_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .mem_size(mem_size), .mem_se(mem_se), .mem_rw(mem_rw),
        .mem_enable(mem_enable), .load_instr(load_instr), .rf_enable(rf_enable),
        .MEM_ALU(MEM_ALU), .MEM_PA(MEM_PA), .MEM_rd(MEM_rd),
        .MEM_PC8(MEM_PC8), .MEM_R31(MEM_R31),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall(stall), .WB_data(WB_data), .WB_rd(WB_rd),
        .WB_rf_enable(WB_rf_enable), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: lane extraction and extension by plain arithmetic.
    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic se,
                                               input logic [31:0] a, input logic [31:0] rd);
        int unsigned off;
        int unsigned v;
        off = int'(a[1:0]);
        if (sz == 2'd0) begin
            v = (rd >> (8 * off)) % 256;
            if (se && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = a[1] ? (rd >> 16) : (rd % 65536);
            if (se && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned off;
        off = int'(a[1:0]);
        if (sz == 2'd0) return 32'(1 << off);
        if (sz == 2'd1) return a[1] ? 32'hC : 32'h3;
        return 32'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] pa);
        if (sz == 2'd0) return (pa % 256) * 32'h01010101;
        if (sz == 2'd1) return (pa % 65536) * 32'h00010001;
        return pa;
    endfunction

    task automatic check_all_zero(input string where);
        chk({where, "_req"},   {31'b0, dm_req}, 0);
        chk({where, "_we"},    {31'b0, dm_we}, 0);
        chk({where, "_be"},    {28'b0, dm_be}, 0);
        chk({where, "_stall"}, {31'b0, stall}, 0);
        chk({where, "_wbd"},   WB_data, 0);
        chk({where, "_wbrd"},  {27'b0, WB_rd}, 0);
        chk({where, "_wbrf"},  {31'b0, WB_rf_enable}, 0);
        chk({where, "_berr"},  {31'b0, bus_err}, 0);
    endtask

    task automatic do_reset();
        mem_enable = 1'b0;
        dm_ack     = 1'b0;
        reset      = 1'b0;
        #2;
        chk("rst_berr", {31'b0, bus_err}, 0);
        reset = 1'b1;
        step();
    endtask

    // One instruction through the stage. d = REQ cycle index of the ack.
    task automatic run_txn(input logic en, input logic [1:0] sz, input logic se,
                           input logic rw, input logic ld, input logic rf,
                           input logic [31:0] alu, input logic [31:0] pa,
                           input logic [4:0] rd, input logic [8:0] pc8,
                           input logic r31, input int d, input logic [31:0] rdat);
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        bit          mis, got_ack;
        mis = TRAP && en && ((sz == 2'd1 && alu[0]) || (sz >= 2'd2 && alu[1:0] != 2'b00));
        exp_rd   = r31 ? 5'd31 : rd;
        exp_data = r31 ? {23'b0, pc8} : (ld && !rw) ? model_load(sz, se, alu, rdat) : alu;
        got_ack  = 1'b0;

        mem_enable = en; mem_size = sz; mem_se = se; mem_rw = rw;
        load_instr = ld; rf_enable = rf; MEM_ALU = alu; MEM_PA = pa;
        MEM_rd = rd; MEM_PC8 = pc8; MEM_R31 = r31;
        dm_ack = 1'($urandom_range(0, 1));   // stray ack must be ignored
        dm_rdata = $urandom;
        #1;
        chk("idle_stall", {31'b0, stall}, {31'b0, en});
        chk("idle_req", {31'b0, dm_req}, 0);
        step();
        dm_ack = 1'b0;

        if (!en) begin
            chk("alu_wbd", WB_data, exp_data);
            chk("alu_wbrd", {27'b0, WB_rd}, {27'b0, exp_rd});
            chk("alu_wbrf", {31'b0, WB_rf_enable}, {31'b0, rf});
        end else begin
            if (!mis) begin
                for (int k = 0; k < T; k++) begin
                    chk("req_req", {31'b0, dm_req}, 1);
                    chk("req_stall", {31'b0, stall}, 1);
                    chk("req_we", {31'b0, dm_we}, {31'b0, rw});
                    chk("req_be", {28'b0, dm_be}, model_be(sz, alu));
                    chk("req_addr", dm_addr, alu & 32'hFFFFFFFC);
                    if (rw) chk("req_wdata", dm_wdata, model_wdata(sz, pa));
                    chk("req_bubble", {31'b0, WB_rf_enable}, 0);
                    if (k == d) begin
                        dm_ack = 1'b1;
                        dm_rdata = rdat;
                        step();
                        dm_ack = 1'b0;
                        dm_rdata = $urandom;
                        got_ack = 1'b1;
                        break;
                    end
                    step();
                end
            end
            if (got_ack) begin
                chk("done_stall", {31'b0, stall}, 0);
                chk("done_req", {31'b0, dm_req}, 0);
                chk("done_berr", {31'b0, bus_err}, 0);
                dm_ack = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
                step();
                dm_ack = 1'b0;
                chk("wb_data", WB_data, exp_data);
                chk("wb_rd", {27'b0, WB_rd}, {27'b0, exp_rd});
                chk("wb_rf", {31'b0, WB_rf_enable}, {31'b0, rf});
            end else begin
                chk("err_stall", {31'b0, stall}, 0);
                chk("err_req", {31'b0, dm_req}, 0);
                chk("err_be", {28'b0, dm_be}, 0);
                chk("err_berr", {31'b0, bus_err}, 1);
                step();
                chk("err_wbrf", {31'b0, WB_rf_enable}, 0);
                chk("err_berr2", {31'b0, bus_err}, 1);
            end
        end
        mem_enable = 1'b0;
        $display("txn %0d: en=%0d size=%0d rw=%0d addr=%h ack_at=%0d wb_data=%h wb_rd=%0d",
                 txn_no, en, sz, rw, alu, got_ack ? d : -1, WB_data, WB_rd);
        txn_no++;
        if (en && !got_ack) do_reset();
    endtask

    initial begin
        reset = 1'b0;
        mem_size = 2'd2; mem_se = 1'b0; mem_rw = 1'b0; mem_enable = 1'b1;
        load_instr = 1'b1; rf_enable = 1'b1; MEM_ALU = 32'h100; MEM_PA = 32'h0;
        MEM_rd = 5'd3; MEM_PC8 = 9'd0; MEM_R31 = 1'b0;
        dm_rdata = 32'h0; dm_ack = 1'b0;
        #12;
        check_all_zero("reset");
        mem_enable = 1'b0;
        #2;
        reset = 1'b1;
        step();

        // Load word, immediate ack.
        run_txn(1, 2'd2, 0, 0, 1, 1, 32'h100, 32'h0, 5'd5, 9'd0, 0, 0, 32'hDEADBEEF);
        // Load byte from lane 3, signed then unsigned.
        run_txn(1, 2'd0, 1, 0, 1, 1, 32'h103, 32'h0, 5'd6, 9'd0, 0, 1, 32'h80123456);
        chk("lb_signed", WB_data, 32'hFFFFFF80);
        run_txn(1, 2'd0, 0, 0, 1, 1, 32'h103, 32'h0, 5'd6, 9'd0, 0, 2, 32'h80123456);
        chk("lb_unsigned", WB_data, 32'h00000080);
        // Store half to upper lanes.
        run_txn(1, 2'd1, 0, 1, 0, 0, 32'h202, 32'h1234, 5'd7, 9'd0, 0, 0, 32'h0);
        // Link instruction.
        run_txn(0, 2'd0, 0, 0, 0, 1, 32'h55, 32'h0, 5'd9, 9'h1A8, 1, 0, 32'h0);
        chk("link_data", WB_data, 32'h000001A8);
        // Ack never arrives.
        run_txn(1, 2'd2, 0, 0, 1, 1, 32'h300, 32'h0, 5'd4, 9'd0, 0, 99, 32'h0);
        // Last wait cycle before timeout still accepts the ack.
        run_txn(1, 2'd1, 1, 0, 1, 1, 32'h402, 32'h0, 5'd8, 9'd0, 0, T - 1, 32'h9ABC0000);
        chk("late_ack", WB_data, 32'hFFFF9ABC);
`ifdef MEMWB_MISALIGN_TRAP_EN
        run_txn(1, 2'd2, 0, 0, 1, 1, 32'h101, 32'h0, 5'd4, 9'd0, 0, 0, 32'h0);
`endif

        // Asynchronous reset in the middle of a request.
        mem_enable = 1'b1; mem_size = 2'd2; mem_rw = 1'b1; load_instr = 1'b0;
        MEM_ALU = 32'h500; MEM_PA = 32'h77;
        #1;
        step();
        chk("mid_req", {31'b0, dm_req}, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        mem_enable = 1'b0;
        #2;
        reset = 1'b1;
        step();

        for (int i = 0; i < 80; i++) begin
            logic en, rw;
            int   d;
            en = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 5));
            run_txn(en, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rw,
                    en & ~rw, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), 9'($urandom_range(0, 511)),
                    ($urandom_range(0, 7) == 0), d, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, 15, maximum cycles waiting for dm_ack before bus error (1..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-005 mem_se  in  1  sign-extend loaded byte/half when 1, zero-extend when 0.
REQ-006 mem_rw  in  1  1 = store, 0 = load.
REQ-007 mem_enable  in  1  memory access requested this cycle.
REQ-008 load_instr  in  1  instruction is a load; writeback takes memory data.
REQ-009 rf_enable  in  1  instruction writes the register file.
REQ-010 MEM_ALU  in  32  ALU result / effective address.
REQ-011 MEM_PA  in  32  store data.
REQ-012 MEM_rd  in  5  destination register.
REQ-013 MEM_PC8  in  9  return address for link instructions.
REQ-014 MEM_R31  in  1  link instruction: destination forced to r31.
REQ-015 dm_req, dm_we  out  1 each  data-memory request / write strobe.
REQ-016 dm_addr  out  32  word-aligned address {MEM_ALU[31:2],2'b00}.
REQ-017 dm_be  out  4  byte enables (bit i = byte lane i, little-endian).
REQ-018 dm_wdata  out  32  store data replicated into the addressed lanes.
REQ-019 dm_rdata  in  32; dm_ack  in  1  read data / access complete (one-cycle pulse).
REQ-020 stall  out  1  upstream must hold all inputs stable while 1.
REQ-021 WB_data  out  32; WB_rd  out  5; WB_rf_enable  out  1  registered writeback bundle.
REQ-022 bus_err  out  1  sticky timeout/alignment error flag.

Function
REQ-023 FSM states IDLE, REQ, DONE, ERR; the block SHALL reset into IDLE.
REQ-024 IDLE: mem_enable=0 -> writeback bundle registered at the next edge, stall=0; mem_enable=1 -> stall=1 combinationally, go to REQ.
REQ-025 REQ: dm_req=1, stall=1; dm_ack=1 -> capture dm_rdata, go to DONE; otherwise increment the 8-bit wait counter.
REQ-026 REQ: wait counter reaching ACK_TIMEOUT with no ack -> go to ERR; counter cleared on entry to REQ.
REQ-027 DONE: stall=0, writeback bundle registered at the edge ending DONE, then IDLE; minimum memory latency 3 cycles (IDLE, REQ, DONE).
REQ-028 ERR: stall=0 for one cycle, bus_err set, WB_rf_enable registered 0, then IDLE.
REQ-029 While stall=1, WB_rf_enable SHALL register 0 (bubble).
REQ-030 dm_be: byte -> 1<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100; word -> 1111.
REQ-031 Load data SHALL be shifted from the addressed lane to bit 0, then sign- or zero-extended per mem_se and mem_size.
REQ-032 WB_data select: MEM_R31 -> {23'b0,MEM_PC8}; else load_instr -> extended load data; else MEM_ALU.
REQ-033 WB_rd = 5'd31 when MEM_R31, else MEM_rd; WB_rf_enable = rf_enable outside bubbles.
REQ-034 Stores (mem_rw=1) SHALL complete via the same FSM but register WB_rf_enable = rf_enable without using dm_rdata.
REQ-035 dm_ack outside REQ SHALL be ignored.

Reset
REQ-036 reset=0 SHALL immediately force state IDLE, counter 0, dm_req 0, dm_we 0, dm_be 0, stall 0, WB_data 0, WB_rd 0, WB_rf_enable 0, bus_err 0, including mid-access.

Configuration
REQ-037 Macro MEMWB_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->ERR without asserting dm_req; undefined: address low bits ignored for alignment (half uses addr[1], word uses lanes 1111).

Verification
REQ-038 Load word, MEM_ALU=0x100, dm_ack in first REQ cycle, dm_rdata=0xDEADBEEF -> WB_data=0xDEADBEEF, stall high exactly 2 cycles.
REQ-039 Load byte signed, addr=0x103, dm_rdata=0x80xxxxxx -> dm_be=1000, WB_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Store half, addr=0x202, MEM_PA=0x1234 -> dm_we=1, dm_be=1100, dm_wdata[31:16]=0x1234.
REQ-041 Link, MEM_R31=1, MEM_PC8=0x1A8 -> WB_rd=31, WB_data=0x000001A8 one cycle later, stall=0.
REQ-042 No dm_ack for 15 cycles -> ERR, bus_err=1, WB_rf_enable=0; reset=0 mid-REQ -> all outputs 0 asynchronously.
REQ-043 With MEMWB_MISALIGN_TRAP_EN, load word addr=0x101 -> dm_req never asserted, bus_err=1.
